// File: rtl/watchdog_reset_generator_if.sv
// Watchdog control/status bundle.
// The master side (software model or control logic) drives enable, kick and
// cause_clear; the slave side (the watchdog) returns its registered status.
//
// Strobe semantics: kick and cause_clear are single-cycle strobes sampled on
// each rising clk edge. There is no ready/acknowledge. A strobe seen at an
// edge is acted on at that edge, or silently dropped if the watchdog is not
// RUNNING (kick) at that edge. enable is a level. Every status signal is a
// registered output.
interface watchdog_reset_generator_if #(
    parameter int CW = 10
);
    logic          enable;
    logic          kick;
    logic          cause_clear;
    logic          reset_request;
    logic          warning;
    logic [1:0]    cause;
    logic [CW-1:0] count;
    logic [1:0]    fsm_state;

    modport master (
        output enable,
        output kick,
        output cause_clear,
        input  reset_request,
        input  warning,
        input  cause,
        input  count,
        input  fsm_state
    );

    modport slave (
        input  enable,
        input  kick,
        input  cause_clear,
        output reset_request,
        output warning,
        output cause,
        output count,
        output fsm_state
    );
endinterface

// File: rtl/watchdog_reset_generator.sv
// Windowed watchdog with sticky cause flags.
// A missed kick (timeout) or a kick that arrives too soon (window violation)
// causes a "bite". A bite drives reset_request high for PULSE_LENGTH cycles.
// reset_request is meant to feed a downstream reset synchronizer/stretcher.
// It must never loop back into this block's own reset_in, because the cause
// flags have to survive the reset they trigger.
// fsm_state exposes the FSM encoding: 0=DISABLED, 1=RUNNING, 2=BITE.
module watchdog_reset_generator #(
    parameter int TIMEOUT      = 1000, // >= 2
    parameter int WINDOW_MIN   = 0,    // 0 disables the early-kick window
    parameter int WARN_CYCLES  = 0,    // 0 disables the warning output
    parameter int PULSE_LENGTH = 7,    // >= 1
    parameter bit LOCK         = 1'b1  // 1: enable cannot disarm once armed
) (
    input  logic                        clk,
    input  logic                        reset_in,
    watchdog_reset_generator_if.slave   wd
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(PULSE_LENGTH + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LENGTH);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
    localparam bit            WIN_EN     = (WINDOW_MIN != 0);
    localparam bit            WARN_EN    = (WARN_CYCLES != 0);
    localparam int            WARN_FROM  = TIMEOUT - WARN_CYCLES;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_BITE     = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] pulse_q;
    logic          reset_request_q;
    logic          warning_q;
    logic [1:0]    cause_q;

    logic          disarm;
    logic          early_kick;
    logic          timeout_hit;
    logic          pulse_done;
    logic          stay_armed;
    logic [CW-1:0] count_inc;
    logic          warn_at_inc;
    logic          bite_early;
    logic          bite_timeout;

    // Decode the RUNNING-state conditions, then order them by priority:
    // disarm > early kick > kick > timeout > count.
    always_comb begin
        disarm       = !wd.enable && !LOCK;
        early_kick   = wd.kick && WIN_EN && (int'(count_q) < WINDOW_MIN);
        timeout_hit  = (count_q == CNT_LAST);
        pulse_done   = (pulse_q == PULSE_LAST);
        stay_armed   = wd.enable || LOCK;
        // count_q never exceeds TIMEOUT-1, so the increment cannot wrap.
        count_inc    = count_q + CNT_ONE;
        // warning is registered, so it is computed from the value count takes next.
        warn_at_inc  = WARN_EN && (int'(count_inc) >= WARN_FROM);
        bite_early   = (state_q == ST_RUNNING) && !disarm && early_kick;
        bite_timeout = (state_q == ST_RUNNING) && !disarm && !wd.kick && timeout_hit;
    end

    // Watchdog FSM. The count, the pulse counter, reset_request and warning
    // are all registered here.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= ST_DISABLED;
            count_q         <= '0;
            pulse_q         <= '0;
            reset_request_q <= 1'b0;
            warning_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    count_q         <= '0;
                    pulse_q         <= '0;
                    reset_request_q <= 1'b0;
                    warning_q       <= 1'b0;
                    if (wd.enable) begin
                        state_q <= ST_RUNNING;
                    end
                end

                ST_RUNNING: begin
                    if (disarm) begin
                        // A kick or timeout arriving at the same edge is dropped.
                        state_q   <= ST_DISABLED;
                        count_q   <= '0;
                        warning_q <= 1'b0;
                    end else if (early_kick) begin
                        state_q         <= ST_BITE;
                        count_q         <= '0;
                        pulse_q         <= PULSE_ONE;
                        reset_request_q <= 1'b1;
                        warning_q       <= 1'b0;
                    end else if (wd.kick) begin
                        // A kick at count TIMEOUT-1 arrives in time and wins.
                        count_q   <= '0;
                        warning_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q         <= ST_BITE;
                        count_q         <= '0;
                        pulse_q         <= PULSE_ONE;
                        reset_request_q <= 1'b1;
                        warning_q       <= 1'b0;
                    end else begin
                        count_q   <= count_inc;
                        warning_q <= warn_at_inc;
                    end
                end

                ST_BITE: begin
                    // kick is ignored here. pulse_q counts high cycles already
                    // issued, starting at 1 on entry.
                    count_q   <= '0;
                    warning_q <= 1'b0;
                    if (pulse_done) begin
                        pulse_q         <= '0;
                        reset_request_q <= 1'b0;
                        state_q         <= stay_armed ? ST_RUNNING : ST_DISABLED;
                    end else begin
                        pulse_q         <= pulse_q + PULSE_ONE;
                        reset_request_q <= 1'b1;
                    end
                end

                default: begin
                    state_q         <= ST_DISABLED;
                    count_q         <= '0;
                    pulse_q         <= '0;
                    reset_request_q <= 1'b0;
                    warning_q       <= 1'b0;
                end
            endcase
        end
    end

    // Sticky cause flags: a bite entry sets its bit even if cause_clear is
    // high at the same edge.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            cause_q <= 2'b00;
        end else begin
            cause_q <= (cause_q & ~{2{wd.cause_clear}}) | {bite_early, bite_timeout};
        end
    end

    assign wd.reset_request = reset_request_q;
    assign wd.warning       = warning_q;
    assign wd.cause         = cause_q;
    assign wd.count         = count_q;
    assign wd.fsm_state     = state_q;

endmodule
